uart_depacketizer: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx.sv | 113 +++++++++++
 rtl/uart_depacketizer.sv | 115 +++++++++++
 tb/tb_uart_depacketizer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, packet sync marker default,
// and the checksum rule used by both the packetizer and the depacketizer.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    PKT_SYNC    = 2'd0,
    PKT_LEN     = 2'd1,
    PKT_PAYLOAD = 2'd2,
    PKT_CSUM    = 2'd3
  } pkt_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Checksum is the XOR of LEN and every payload byte, starting from zero.
  localparam logic [7:0] CSUM_INIT = 8'h00;

  function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                             input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer plus mid-bit sampling FSM.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   serial_in     raw asynchronous RX line (idles high)
//   rx_byte       last received byte (stable from stop sample until next data bit)
//   byte_valid    1-cycle strobe, cycle after a good stop sample
//   framing_err   1-cycle strobe, cycle after a low stop sample
//   rx_busy       high while a byte is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_d, framing_err_d;

  assign rx_s    = sync_q[1];
  assign rx_byte = shift_q;

  // Metastability guard; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_valid  <= byte_valid_d;
      framing_err <= framing_err_d;
      rx_busy     <= (state_d != RX_IDLE);
    end
  end

  // Next-state: half-bit wait to centre on the start bit, then full-bit steps.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d         = '0;
          byte_valid_d  = rx_s;
          framing_err_d = !rx_s;
          state_d       = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_depacketizer.sv
// Recovers SYNC/LEN/payload/CSUM packets from a UART line and streams the
// payload out with a strobe, then reports completion with a checksum verdict.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   serial_in       raw RX line
//   data_out        payload byte, valid with data_out_valid
//   data_out_valid  1-cycle strobe per payload byte
//   pkt_len         LEN field of the current packet
//   pkt_done        1-cycle strobe when the checksum byte arrives
//   pkt_ok          checksum verdict, valid with pkt_done
//   pkt_error       1-cycle strobe on a framing error inside a packet
//   rx_busy         receiver is mid-byte
module uart_depacketizer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic [7:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       pkt_error,
  output logic       rx_busy
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       framing_err;

  pkt_state_e state_q, state_d;
  logic [7:0] len_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] csum_q, csum_d;
  logic       done_d, ok_d, err_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .framing_err(framing_err),
    .rx_busy    (rx_busy)
  );

  // Payload leaves in the same cycle as the receiver's registered strobe;
  // both terms come straight from flops.
  assign data_out       = rx_byte;
  assign data_out_valid = byte_valid && (state_q == PKT_PAYLOAD);

  // Packet state and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PKT_SYNC;
      pkt_len   <= '0;
      rem_q     <= '0;
      csum_q    <= CSUM_INIT;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_len   <= len_d;
      rem_q     <= rem_d;
      csum_q    <= csum_d;
      pkt_done  <= done_d;
      pkt_ok    <= ok_d;
      pkt_error <= err_d;
    end
  end

  // Packet parser; a framing error aborts any packet in progress.
  always_comb begin
    state_d = state_q;
    len_d   = pkt_len;
    rem_d   = rem_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    ok_d    = pkt_ok;
    err_d   = 1'b0;
    if (framing_err && (state_q != PKT_SYNC)) begin
      err_d   = 1'b1;
      state_d = PKT_SYNC;
    end else if (byte_valid) begin
      case (state_q)
        PKT_SYNC: begin
          if (rx_byte == SYNC_BYTE) state_d = PKT_LEN;
        end
        PKT_LEN: begin
          len_d   = rx_byte;
          rem_d   = rx_byte;
          csum_d  = csum_update(CSUM_INIT, rx_byte);
          state_d = (rx_byte == 8'd0) ? PKT_CSUM : PKT_PAYLOAD;
        end
        PKT_PAYLOAD: begin
          csum_d = csum_update(csum_q, rx_byte);
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = PKT_CSUM;
        end
        PKT_CSUM: begin
          done_d  = 1'b1;
          ok_d    = (rx_byte == csum_q);
          state_d = PKT_SYNC;
        end
        default: state_d = PKT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_depacketizer.sv
// Bench for uart_depacketizer: directed packet table, random packets built
// from the packet rules, and hand-written glitch and reset sequences.
module tb_uart_depacketizer;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [7:0] pkt_len;
  logic       pkt_done;
  logic       pkt_ok;
  logic       pkt_error;
  logic       rx_busy;

  uart_depacketizer #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .pkt_len       (pkt_len),
    .pkt_done      (pkt_done),
    .pkt_ok        (pkt_ok),
    .pkt_error     (pkt_error),
    .rx_busy       (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] b[16];
    int         bad_idx;
    int         exp_nd;
    logic [7:0] exp_d[8];
    int         exp_done;
    logic       exp_ok;
    logic [7:0] exp_len;
    int         exp_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mon_data[$];
  logic       mon_ok[$];
  logic [7:0] mon_len[$];
  int         err_total = 0;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_valid) mon_data.push_back(data_out);
      if (pkt_done) begin
        mon_ok.push_back(pkt_ok);
        mon_len.push_back(pkt_len);
      end
      if (pkt_error) err_total = err_total + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One ideal 8N1 frame followed by one idle bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_cycles(CPB);
    end
    serial_in = stop_bit;
    wait_cycles(CPB);
    serial_in = 1'b1;
    wait_cycles(CPB);
  endtask

  // Bytes and expected data are right-aligned hex, first byte most significant.
  function automatic vec_t mk(input int n, input logic [63:0] bytes, input int bad_idx,
                              input int nd, input logic [31:0] d, input int done,
                              input logic ok, input logic [7:0] len, input int err);
    vec_t v;
    v.n = n;
    for (int i = 0; i < 16; i++) v.b[i] = 8'h00;
    for (int i = 0; i < 8; i++) v.exp_d[i] = 8'h00;
    for (int i = 0; i < n; i++) v.b[i] = bytes[8*(n-1-i) +: 8];
    for (int i = 0; i < nd; i++) v.exp_d[i] = d[8*(nd-1-i) +: 8];
    v.bad_idx  = bad_idx;
    v.exp_nd   = nd;
    v.exp_done = done;
    v.exp_ok   = ok;
    v.exp_len  = len;
    v.exp_err  = err;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    int e0;
    logic [31:0] got;
    mon_data.delete();
    mon_ok.delete();
    mon_len.delete();
    e0 = err_total;
    for (int i = 0; i < v.n; i++) send_byte(v.b[i], (i != v.bad_idx));
    wait_cycles(4);
    chk({tag, " data_count"}, mon_data.size(), v.exp_nd);
    for (int i = 0; i < v.exp_nd; i++) begin
      got = (i < mon_data.size()) ? {24'h0, mon_data[i]} : 32'hDEAD;
      chk($sformatf("%s data[%0d]", tag, i), got, v.exp_d[i]);
    end
    chk({tag, " done_count"}, mon_ok.size(), v.exp_done);
    if (v.exp_done > 0 && mon_ok.size() > 0) begin
      chk({tag, " pkt_ok"}, mon_ok[0], v.exp_ok);
      chk({tag, " pkt_len"}, mon_len[0], v.exp_len);
    end
    chk({tag, " error_count"}, err_total - e0, v.exp_err);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    bit seen_idle;

    vecs[0] = mk(6, 64'hA5_03_11_22_33_03, -1, 3, 32'h11_22_33, 1, 1'b1, 8'd3, 0);
    vecs[1] = mk(3, 64'hA5_00_00, -1, 0, 32'h0, 1, 1'b1, 8'd0, 0);
    vecs[2] = mk(5, 64'hA5_02_AA_BB_00, -1, 2, 32'hAA_BB, 1, 1'b0, 8'd2, 0);
    vecs[3] = mk(6, 64'h5A_FF_A5_01_7E_7F, -1, 1, 32'h7E, 1, 1'b1, 8'd1, 0);
    vecs[4] = mk(8, 64'hA5_02_10_55_A5_01_42_43, 3, 2, 32'h10_42, 1, 1'b1, 8'd1, 1);
    vecs[5] = mk(5, 64'hA5_02_A5_A5_02, -1, 2, 32'hA5_A5, 1, 1'b1, 8'd2, 0);
    vecs[6] = mk(4, 64'h33_A5_00_00, 0, 0, 32'h0, 1, 1'b1, 8'd0, 0);

    rst       = 1'b1;
    serial_in = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_out_valid", data_out_valid, 1'b0);
    chk("reset pkt_len", pkt_len, 8'h00);
    chk("reset pkt_done", pkt_done, 1'b0);
    chk("reset pkt_ok", pkt_ok, 1'b0);
    chk("reset pkt_error", pkt_error, 1'b0);
    chk("reset rx_busy", rx_busy, 1'b0);
    rst = 1'b0;
    wait_cycles(20);

    for (int k = 0; k < 7; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

    // Random packets, optionally preceded by junk and with a corrupted checksum.
    for (int r = 0; r < 16; r++) begin
      int junk, len, idx;
      logic [7:0] cs, jb, pb;
      bit bad;
      v = mk(0, 64'h0, -1, 0, 32'h0, 1, 1'b1, 8'd0, 0);
      junk = $urandom_range(0, 2);
      len  = $urandom_range(0, 6);
      bad  = ($urandom_range(0, 3) == 0);
      idx  = 0;
      for (int j = 0; j < junk; j++) begin
        jb = 8'($urandom());
        if (jb == 8'hA5) jb = 8'h5A;
        v.b[idx++] = jb;
      end
      v.b[idx++] = 8'hA5;
      v.b[idx++] = 8'(len);
      cs = 8'(len);
      for (int j = 0; j < len; j++) begin
        pb = 8'($urandom());
        v.b[idx++] = pb;
        v.exp_d[j] = pb;
        cs = cs ^ pb;
      end
      if (bad) cs = cs ^ (8'h01 << $urandom_range(0, 7));
      v.b[idx++] = cs;
      v.n       = idx;
      v.exp_nd  = len;
      v.exp_ok  = !bad;
      v.exp_len = 8'(len);
      apply_vec(v, $sformatf("rand%0d", r));
    end

    // Short low glitch on an idle line must not produce a byte.
    @(posedge clk); #1;
    serial_in = 1'b0;
    wait_cycles(4);
    serial_in = 1'b1;
    @(negedge clk);
    chk("glitch rx_busy_high", rx_busy, 1'b1);
    seen_idle = 1'b0;
    for (int k = 0; k < 7 && !seen_idle; k++) begin
      @(negedge clk);
      if (!rx_busy) seen_idle = 1'b1;
    end
    chk("glitch rx_busy_drop", seen_idle, 1'b1);
    wait_cycles(20);
    apply_vec(mk(4, 64'hA5_01_55_54, -1, 1, 32'h55, 1, 1'b1, 8'd1, 0), "after_glitch");

    // Asynchronous reset in the middle of a payload byte.
    mon_data.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    serial_in = 1'b0;
    wait_cycles(CPB);
    serial_in = 1'b0;
    wait_cycles(CPB);
    serial_in = 1'b1;
    wait_cycles(CPB);
    chk("pre_reset pkt_len", pkt_len, 8'd4);
    chk("pre_reset rx_busy", rx_busy, 1'b1);
    chk("pre_reset data_count", mon_data.size(), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst data_out", data_out, 8'h00);
    chk("midrst data_out_valid", data_out_valid, 1'b0);
    chk("midrst pkt_len", pkt_len, 8'h00);
    chk("midrst pkt_done", pkt_done, 1'b0);
    chk("midrst pkt_ok", pkt_ok, 1'b0);
    chk("midrst pkt_error", pkt_error, 1'b0);
    chk("midrst rx_busy", rx_busy, 1'b0);
    serial_in = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(20);
    apply_vec(mk(4, 64'hA5_01_09_08, -1, 1, 32'h09, 1, 1'b1, 8'd1, 0), "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
